// File: rtl/decode_stage.sv
// decode_stage: splits fetch packets into fields/class bits behind a 2-entry elastic buffer; optional trap via DECODE_STAGE_ILLEGAL_TRAP_EN.
// Latency: one cycle from accept to out_*; one instruction per cycle while out_ready is high.
// Backpressure: skid register absorbs one extra packet; in_ready is purely registered (no out_ready path).
module decode_stage #(
    parameter int NUM_THREADS = 32,
    parameter int ADDR_W      = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_THREADS-1:0] in_exec_mask,
    input  logic [ADDR_W-1:0]      in_pc,
    input  logic [31:0]            in_insn,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_THREADS-1:0] out_exec_mask,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [7:0]             out_opcode,
    output logic [3:0]             out_rd,
    output logic [3:0]             out_rs1,
    output logic [3:0]             out_rs2,
    output logic [63:0]            out_imm,
    output logic                   out_is_branch,
    output logic                   out_is_mem,
    output logic                   out_uses_imm,
    output logic                   halted,
    output logic                   illegal
);

    localparam logic [7:0] OP_HALT            = 8'h01;
    localparam logic [7:0] OP_JMP_ALWAYS      = 8'h02;
    localparam logic [7:0] OP_JMP_EQUAL       = 8'h03;
    localparam logic [7:0] OP_JMP_NOT_EQUAL   = 8'h04;
    localparam logic [7:0] OP_JMP_GREATER     = 8'h05;
    localparam logic [7:0] OP_JMP_GREATER_EQ  = 8'h06;
    localparam logic [7:0] OP_JMP_LOWER       = 8'h07;
    localparam logic [7:0] OP_JMP_LOWER_EQ    = 8'h08;
    localparam logic [7:0] OP_LOAD_RESTORE_PC = 8'h09;
    localparam logic [7:0] OP_MOVE_R_IMM      = 8'h0A;
    localparam logic [7:0] OP_LOAD            = 8'h0D;
    localparam logic [7:0] OP_STORE           = 8'h0E;

`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [NUM_THREADS-1:0] exec_mask;
        logic [ADDR_W-1:0]      pc;
        logic [7:0]             opcode;
        logic [3:0]             rd;
        logic [3:0]             rs1;
        logic [3:0]             rs2;
        logic [63:0]            imm;
        logic                   is_branch;
        logic                   is_mem;
        logic                   uses_imm;
    } pkt_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state, state_nxt;
    pkt_t   dec, out_reg, skid_reg;
    logic   halted_q, illegal_q;
    logic   op_illegal, accept, push, drain;
    logic   load_out_dec, load_out_skid, load_skid;

    always_comb begin
        dec           = '0;
        dec.exec_mask = in_exec_mask;
        dec.pc        = in_pc;
        dec.opcode    = in_insn[7:0];
        dec.rd        = in_insn[11:8];
        dec.rs1       = in_insn[15:12];
        dec.rs2       = in_insn[19:16];
        dec.imm       = {{52{in_insn[31]}}, in_insn[31:20]};
        case (in_insn[7:0])
            OP_JMP_ALWAYS, OP_JMP_EQUAL, OP_JMP_NOT_EQUAL, OP_JMP_GREATER,
            OP_JMP_GREATER_EQ, OP_JMP_LOWER, OP_JMP_LOWER_EQ: begin
                dec.is_branch = 1'b1;
                dec.uses_imm  = 1'b1;
            end
            OP_LOAD_RESTORE_PC: dec.is_branch = 1'b1;
            OP_MOVE_R_IMM:      dec.uses_imm  = 1'b1;
            OP_LOAD, OP_STORE: begin
                dec.is_mem   = 1'b1;
                dec.uses_imm = 1'b1;
            end
            default: ;
        endcase
    end

    assign op_illegal = in_insn[7:0] > OP_STORE;
    assign accept     = in_valid && in_ready;
    // A trapped illegal opcode is consumed but never enters the buffer.
    assign push       = accept && !(TRAP_EN && op_illegal);
    assign drain      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !drain)      state_nxt = TWO;
                else if (!push && drain) state_nxt = EMPTY;
            end
            TWO:     if (drain) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid     = (state != EMPTY);
        in_ready      = (state != TWO) && !halted_q && !illegal_q;
        load_out_dec  = push && ((state == EMPTY) || (state == ONE && drain));
        load_skid     = push && (state == ONE) && !drain;
        load_out_skid = (state == TWO) && drain;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_reg  <= '0;
            skid_reg <= '0;
        end else begin
            if (load_out_dec)       out_reg <= dec;
            else if (load_out_skid) out_reg <= skid_reg;
            if (load_skid)          skid_reg <= dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (accept && in_insn[7:0] == OP_HALT)  halted_q  <= 1'b1;
            if (TRAP_EN && accept && op_illegal)    illegal_q <= 1'b1;
        end
    end

    assign halted        = halted_q;
    assign illegal       = illegal_q;
    assign out_exec_mask = out_reg.exec_mask;
    assign out_pc        = out_reg.pc;
    assign out_opcode    = out_reg.opcode;
    assign out_rd        = out_reg.rd;
    assign out_rs1       = out_reg.rs1;
    assign out_rs2       = out_reg.rs2;
    assign out_imm       = out_reg.imm;
    assign out_is_branch = out_reg.is_branch;
    assign out_is_mem    = out_reg.is_mem;
    assign out_uses_imm  = out_reg.uses_imm;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: scoreboard of expected decoded packets, pushed on accept and popped on drain.
module tb_decode_stage;

`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_exec_mask = '0;
    logic [63:0] in_pc = '0;
    logic [31:0] in_insn = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_exec_mask;
    logic [63:0] out_pc;
    logic [7:0]  out_opcode;
    logic [3:0]  out_rd, out_rs1, out_rs2;
    logic [63:0] out_imm;
    logic        out_is_branch, out_is_mem, out_uses_imm;
    logic        halted, illegal;

    typedef struct packed {
        logic [31:0] mask;
        logic [63:0] pc;
        logic [7:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [63:0] imm;
        logic        br;
        logic        mem;
        logic        uimm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   popped = 0;

    decode_stage #(.NUM_THREADS(32), .ADDR_W(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_exec_mask(in_exec_mask), .in_pc(in_pc), .in_insn(in_insn),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exec_mask(out_exec_mask), .out_pc(out_pc), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_is_branch(out_is_branch), .out_is_mem(out_is_mem), .out_uses_imm(out_uses_imm),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] mask, input logic [63:0] pc, input logic [31:0] insn);
        exp_t e;
        logic [7:0] op;
        op     = insn[7:0];
        e.mask = mask;
        e.pc   = pc;
        e.op   = op;
        e.rd   = insn[11:8];
        e.rs1  = insn[15:12];
        e.rs2  = insn[19:16];
        e.imm  = {{52{insn[31]}}, insn[31:20]};
        e.br   = (op >= 8'h02 && op <= 8'h09);
        e.mem  = (op == 8'h0D || op == 8'h0E);
        e.uimm = (op >= 8'h02 && op <= 8'h08) || op == 8'h0A || e.mem;
        return e;
    endfunction

    // Scoreboard: transfers are judged at the negedge preceding the edge that performs them.
    always @(negedge clk) begin
        exp_t got, e;
        if (!reset_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                got = {out_exec_mask, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
                       out_imm, out_is_branch, out_is_mem, out_uses_imm};
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_output got pc=%h opcode=%h required none", out_pc, out_opcode);
                end else begin
                    e = q.pop_front();
                    popped++;
                    if (got !== e) $display("FAIL packet got=%h required=%h", got, e);
                    else passes++;
                end
            end
            if (in_valid && in_ready && !(TRAP && in_insn[7:0] > 8'h0E))
                q.push_back(model(in_exec_mask, in_pc, in_insn));
        end
    end

    // Holds a packet on the input until accepted; returns at posedge+1 with the packet taken.
    task automatic offer(input logic [31:0] insn, input logic [63:0] pc, input logic [31:0] mask);
        int n;
        in_valid = 1'b1; in_insn = insn; in_pc = pc; in_exec_mask = mask;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
        end
        checks++;
        if (n == 50) $display("FAIL offer_timeout pc=%h in_ready=%b required 1", pc, in_ready);
        else begin passes++; @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n  = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b required 0", out_valid); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b required 1", in_ready); else passes++;
        checks++; if (halted !== 1'b0) $display("FAIL rst_halted got=%b required 0", halted); else passes++;
        checks++; if (illegal !== 1'b0) $display("FAIL rst_illegal got=%b required 0", illegal); else passes++;
        checks++; if ({out_pc, out_opcode, out_imm, out_exec_mask} !== '0)
            $display("FAIL rst_data got pc=%h op=%h imm=%h required 0", out_pc, out_opcode, out_imm); else passes++;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        offer(32'h0020_320B, 64'h100, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) $display("FAIL add_latency out_valid=%b required 1", out_valid); else passes++;
        checks++; if ({out_opcode, out_rd, out_rs1, out_rs2} !== {8'h0B, 4'd2, 4'd3, 4'd0})
            $display("FAIL add_fields got op=%h rd=%h rs1=%h rs2=%h required 0b 2 3 0", out_opcode, out_rd, out_rs1, out_rs2);
        else passes++;
        checks++; if (out_imm !== 64'h2) $display("FAIL add_imm got=%h required 2", out_imm); else passes++;
        checks++; if ({out_is_branch, out_is_mem, out_uses_imm} !== 3'b000)
            $display("FAIL add_class got=%b required 000", {out_is_branch, out_is_mem, out_uses_imm}); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_jmp();
        out_ready = 1'b1;
        offer(32'hFFF0_0002, 64'h104, 32'h0000_00FF);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL jmp_imm got=%h required ffffffffffffffff", out_imm); else passes++;
        checks++; if ({out_is_branch, out_is_mem, out_uses_imm} !== 3'b101)
            $display("FAIL jmp_class got=%b required 101", {out_is_branch, out_is_mem, out_uses_imm}); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int start;
        start = popped;
        out_ready = 1'b0;
        offer(32'h0051_200D, 64'h200, 32'h0000_0001);
        offer(32'h8003_450E, 64'h208, 32'h0000_0003);
        in_valid = 1'b1; in_insn = 32'h0070_010A; in_pc = 64'h210; in_exec_mask = 32'h0000_0007;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got=%b required 0", in_ready); else passes++;
        checks++; if (out_pc !== 64'h200) $display("FAIL full_head got pc=%h required 200", out_pc); else passes++;
        @(posedge clk); #1; @(posedge clk); #1;
        @(negedge clk);
        checks++; if ({out_valid, out_pc, out_opcode} !== {1'b1, 64'h200, 8'h0D})
            $display("FAIL stall_hold got v=%b pc=%h op=%h required 1 200 0d", out_valid, out_pc, out_opcode); else passes++;
        @(posedge clk); #1;
        out_ready = 1'b1;
        offer(32'h0070_010A, 64'h210, 32'h0000_0007);
        offer(32'h0003_210C, 64'h218, 32'h0000_000F);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (popped - start !== 4) $display("FAIL stream_count got=%0d required 4", popped - start); else passes++;
    endtask

    task automatic test_halt();
        int start;
        start = popped;
        out_ready = 1'b1;
        offer(32'h0000_0001, 64'h300, 32'hFFFF_FFFF);
        in_valid = 1'b1; in_insn = 32'h0000_0000; in_pc = 64'h304;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({halted, in_ready} !== 2'b10)
                $display("FAIL halt_block cycle %0d got halted=%b in_ready=%b required 1 0", i, halted, in_ready); else passes++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (popped - start !== 1) $display("FAIL halt_emitted got=%0d required 1", popped - start); else passes++;
        do_reset();
        @(negedge clk);
        checks++; if ({halted, in_ready} !== 2'b01)
            $display("FAIL halt_clear got halted=%b in_ready=%b required 0 1", halted, in_ready); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        int start;
        start = popped;
        out_ready = 1'b1;
        offer(32'h0000_0020, 64'h400, 32'h0000_0010);
        in_valid = 1'b0;
        @(negedge clk);
        if (TRAP) begin
            checks++; if ({illegal, in_ready, out_valid} !== 3'b100)
                $display("FAIL illegal_trap got illegal=%b in_ready=%b out_valid=%b required 1 0 0", illegal, in_ready, out_valid);
            else passes++;
        end else begin
            checks++; if ({illegal, out_valid, out_opcode, out_is_branch, out_is_mem, out_uses_imm} !== {1'b0, 1'b1, 8'h20, 3'b000})
                $display("FAIL illegal_fwd got illegal=%b v=%b op=%h cls=%b required 0 1 20 000",
                         illegal, out_valid, out_opcode, {out_is_branch, out_is_mem, out_uses_imm});
            else passes++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (popped - start !== (TRAP ? 0 : 1))
            $display("FAIL illegal_count got=%0d required %0d", popped - start, TRAP ? 0 : 1); else passes++;
        do_reset();
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        out_ready = 1'b0;
        offer(32'h0000_000B, 64'h500, 32'h1);
        offer(32'h0000_000C, 64'h508, 32'h1);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk); #1;
        checks++; if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL midrst got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready); else passes++;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL midrst_leak got %0d valid cycles required 0", seen); else passes++;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_jmp();
        test_back_to_back();
        test_halt();
        test_illegal();
        test_reset_mid();
        checks++; if (q.size() !== 0) $display("FAIL leftover got=%0d required 0", q.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
